// File: rtl/ps2_keyboard_tx.sv
//==============================================================================
// Module   : ps2_keyboard_tx
// Brief    : PS/2 device-side transmitter; serializes [E0][F0]code key events
//            as 11-bit odd-parity frames and backs off on host inhibit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_keyboard_tx #(
    parameter int CLK_HALF = 2500,
    parameter int BYTE_GAP = 2500
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_ext,
    input  logic       key_break,
    output logic       key_ready,
    output logic       ps2_clk_o,
    output logic       ps2_dat_o,
    input  logic       ps2_clk_i,
    output logic       busy,
    output logic       byte_done,
    output logic [7:0] abort_cnt
);

    localparam int c_CNT_MAX = (CLK_HALF > BYTE_GAP) ? CLK_HALF : BYTE_GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLK_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(BYTE_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_INH_FIRST = c_CNT_W'(2);
    localparam logic [3:0]         c_STOP_IDX  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_BIT_HI  = 3'd2,
        S_BIT_LO  = 3'd3,
        S_GAP     = 3'd4,
        S_INHIBIT = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_clk_meta;
    logic                 r_clk_s;
    logic [23:0]          r_seq;
    logic [1:0]           r_left;
    logic [10:0]          r_frame;
    logic [3:0]           r_idx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_clk_o;
    logic                 r_dat_o;
    logic                 r_byte_done;
    logic [7:0]           r_abort_cnt;

    logic [23:0]          w_seq;
    logic [1:0]           w_left;
    logic [7:0]           w_byte;
    logic [3:0]           w_next_idx;

    assign w_byte     = r_seq[7:0];
    assign w_next_idx = r_idx + 4'd1;

    // Byte list packed with the first byte to send in the low octet.
    always_comb begin
        w_seq  = {16'h0000, key_code};
        w_left = 2'd0;
        case ({key_ext, key_break})
            2'b11:   begin w_seq = {key_code, 8'hF0, 8'hE0};   w_left = 2'd2; end
            2'b10:   begin w_seq = {8'h00, key_code, 8'hE0};   w_left = 2'd1; end
            2'b01:   begin w_seq = {8'h00, key_code, 8'hF0};   w_left = 2'd1; end
            default: begin w_seq = {16'h0000, key_code};       w_left = 2'd0; end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_clk_meta <= 1'b1;
            r_clk_s    <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_i;
            r_clk_s    <= r_clk_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_seq       <= '0;
            r_left      <= 2'd0;
            r_frame     <= '1;
            r_idx       <= 4'd0;
            r_cnt       <= c_CNT_ZERO;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_clk_o     <= 1'b1;
            r_dat_o     <= 1'b1;
            r_byte_done <= 1'b0;
            r_abort_cnt <= 8'd0;
        end else begin
            r_byte_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (key_valid) begin
                        r_seq   <= w_seq;
                        r_left  <= w_left;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= r_clk_s ? S_LOAD : S_INHIBIT;
                    end
                end
                S_LOAD: begin
                    r_frame <= {1'b1, ~^w_byte, w_byte, 1'b0};
                    r_idx   <= 4'd0;
                    r_cnt   <= c_CNT_ZERO;
                    r_clk_o <= 1'b1;
                    r_dat_o <= 1'b0;
                    r_state <= S_BIT_HI;
                end
                S_BIT_HI: begin
                    // The first two cycles are skipped to let our own released
                    // clock propagate through the synchronizer.
                    if (r_cnt >= c_INH_FIRST && !r_clk_s && r_idx < c_STOP_IDX) begin
                        r_clk_o <= 1'b1;
                        r_dat_o <= 1'b1;
                        r_cnt   <= c_CNT_ZERO;
                        if (r_abort_cnt != 8'hFF) begin
                            r_abort_cnt <= r_abort_cnt + 8'd1;
                        end
                        r_state <= S_INHIBIT;
                    end else if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= c_CNT_ZERO;
                        r_clk_o <= 1'b0;
                        r_state <= S_BIT_LO;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_BIT_LO: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt   <= c_CNT_ZERO;
                        r_clk_o <= 1'b1;
                        if (r_idx == c_STOP_IDX) begin
                            r_dat_o     <= 1'b1;
                            r_byte_done <= 1'b1;
                            r_state     <= S_GAP;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_dat_o <= r_frame[w_next_idx];
                            r_state <= S_BIT_HI;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (!r_clk_s) begin
                        r_cnt <= c_CNT_ZERO;
                    end else if (r_cnt == c_GAP_LAST) begin
                        r_cnt <= c_CNT_ZERO;
                        if (r_left != 2'd0) begin
                            r_seq   <= {8'h00, r_seq[23:8]};
                            r_left  <= r_left - 2'd1;
                            r_state <= S_LOAD;
                        end else begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_INHIBIT: begin
                    // Retransmit the current byte only after a full quiet hold.
                    if (!r_clk_s) begin
                        r_cnt <= c_CNT_ZERO;
                    end else if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_clk_o <= 1'b1;
                    r_dat_o <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign key_ready = r_ready;
    assign busy      = r_busy;
    assign ps2_clk_o = r_clk_o;
    assign ps2_dat_o = r_dat_o;
    assign byte_done = r_byte_done;
    assign abort_cnt = r_abort_cnt;

endmodule

`default_nettype wire

// File: doc/ps2_keyboard_tx.md
Name: ps2_keyboard_tx

Overview:
- PS/2 device-side (keyboard-emulator) transmitter: the sending end of the PS/2 link that the drawing front end of neural_network_top receives on.
- Accepts a key event (scan code, extended flag, make/break flag) and serializes the required byte sequence (optional E0, optional F0, code) onto PS2 clock/data lines.
- Frames are 11-bit, odd parity, timing-correct, and honour host inhibit.
- Used as a synthesizable stimulus source in benches and in FPGA loopback tests.

Parameters:
- CLK_HALF, 2500, PS/2 clock half-period in CLOCK_50 cycles (2500 gives 10 kHz); minimum 4.
- BYTE_GAP, 2500, idle cycles with both lines high between bytes, and the release hold required before a retry.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- key_valid  in  1  key event request.
- key_code  in  8  scan code.
- key_ext  in  1  prepend E0.
- key_break  in  1  prepend F0 (release).
- key_ready  out  1  high when idle; an event is accepted on key_valid & key_ready.
- ps2_clk_o  out  1  PS/2 clock drive (0 = pull low, 1 = release).
- ps2_dat_o  out  1  PS/2 data drive (0 = pull low, 1 = release).
- ps2_clk_i  in  1  sensed PS/2 clock line (asynchronous; host may hold low).
- busy  out  1  sequence in progress.
- byte_done  out  1  one-cycle pulse after the stop bit of each byte completes.
- abort_cnt  out  8  saturating count of host-inhibit aborts.

Behaviour:
- Reset (asynchronous, immediate): ps2_clk_o=1, ps2_dat_o=1, key_ready=1, busy=0, byte_done=0, abort_cnt=0, FSM=IDLE.
- ps2_clk_i passes through a 2-flop synchronizer (clk_s).
- Accept: on key_valid & key_ready, latch all key fields. Byte list is [E0 if ext][F0 if break][code], 1 to 3 bytes in order. key_ready=0 and busy=1 from the next cycle until the last gap ends. key_valid while not ready is ignored.
- FSM states: IDLE, LOAD, BIT_HI, BIT_LO, GAP, INHIBIT.
  - IDLE: accept, then go to LOAD.
  - LOAD (1 cycle): build the 11-bit frame: start 0, data[0..7] LSB first, parity = ~^data (odd), stop 1. Bit index = 0.
  - BIT_HI (CLK_HALF cycles): ps2_clk_o=1; ps2_dat_o = frame[index], set on entry. Then go to BIT_LO.
  - BIT_LO (CLK_HALF cycles): ps2_clk_o=0. The host samples on this falling edge. On exit: if index=10, go to GAP; else index+1 and go to BIT_HI.
  - Frame length is exactly 22*CLK_HALF cycles from first BIT_HI entry to GAP entry.
  - GAP (BYTE_GAP cycles): both lines 1. byte_done pulses in the first GAP cycle. Then go to LOAD for the next byte, or to IDLE after the last byte.
- Host inhibit:
  - Qualifying condition: in BIT_HI, from the 3rd cycle of the phase onward (covers synchronizer lag), clk_s=0 with index <= 9.
  - Action: release both lines next cycle, abort_cnt+1 (saturates at 255), go to INHIBIT.
  - Inhibit at index 10 (stop bit) is ignored; the frame completes.
  - INHIBIT: lines released. After clk_s has been continuously 1 for BYTE_GAP cycles, go to LOAD with the same byte (full retransmit from start bit). Bytes already completed are not resent.
  - Inhibit in IDLE: key_ready stays 1; an accepted event enters INHIBIT instead of LOAD while clk_s=0.
  - Inhibit in GAP: the gap counter restarts when clk_s returns to 1.
- Counters are sized with clog2 of the largest parameter. No other outputs change mid-bit.

Test Plan:
- All tests use CLK_HALF=4, BYTE_GAP=8.
- Make 0x74, ext=0, brk=0 -> one frame. Data at each ps2_clk_o fall: 0,0,0,1,0,1,1,1,0,1,1 (start, LSB-first 0x74, parity 1, stop). 88 cycles from BIT_HI to GAP; byte_done once; key_ready back to 1 after 8 gap cycles.
- Extended break 0x6B -> three frames E0 (parity 0), F0 (parity 1), 6B (parity 0). Each pair separated by 8 idle-high cycles; 3 byte_done pulses; busy continuous throughout.
- Hold key_valid=1 with code 0x72 across the whole sequence -> a second event is accepted only on the cycle key_ready returns to 1; no event is lost or duplicated beyond that one.
- Force ps2_clk_i=0 during BIT_HI of index 5 for 20 cycles -> lines released within 4 cycles; abort_cnt=1. Retransmit of the same byte from the start bit begins 8 cycles after release; decoded byte is correct.
- Force ps2_clk_i=0 during the stop-bit BIT_HI -> no abort; abort_cnt=0; byte_done pulses.
- Deassert resetn mid-frame (BIT_LO, index 3) -> ps2_clk_o=1 and ps2_dat_o=1 in the same cycle; key_ready=1, busy=0. After release, a new event transmits cleanly.
